// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial source feeding the sequence detector's serial start input.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per clock.
module bit_stream_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic               pause,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               gap,
  output logic [COUNT_W-1:0] word_count
);

  localparam int unsigned BL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BL_W-1:0]  bits_left;

  logic             accept;
  logic             done;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    din_ready = 1'b0;
    case (state)
      IDLE:    din_ready = 1'b1;
      SHIFT:   din_ready = (bits_left == '0) && !pause;
      default: din_ready = 1'b0;
    endcase
  end

  assign accept = din_valid && din_ready;
  // Last bit on bit_out and not paused: the current word completes at this edge.
  assign done   = (state == SHIFT) && !pause && (bits_left == '0);

  always_comb begin
    first_bit = 1'b0;
    next_bit  = 1'b0;
    load_rest = '0;
    shifted   = '0;
    if (LSB_FIRST != 0) begin
      first_bit = din[0];
      load_rest = din >> 1;
      next_bit  = shreg[0];
      shifted   = shreg >> 1;
    end else begin
      first_bit = din[WIDTH-1];
      load_rest = din << 1;
      next_bit  = shreg[WIDTH-1];
      shifted   = shreg << 1;
    end
  end

  // Accept is handled ahead of the state decode: IDLE and a completing SHIFT
  // reload identically, which is what makes back-to-back words gapless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bits_left  <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      gap        <= 1'b0;
      word_count <= '0;
    end else begin
      gap <= 1'b0;
      if (done && (word_count != '1)) begin
        word_count <= word_count + COUNT_W'(1);
      end
      if (accept) begin
        state     <= SHIFT;
        bit_out   <= first_bit;
        shreg     <= load_rest;
        bits_left <= BL_W'(WIDTH - 1);
        bit_valid <= 1'b1;
      end else if (done) begin
        state     <= IDLE;
        bit_out   <= 1'b0;
        bit_valid <= 1'b0;
        gap       <= 1'b1;
      end else if ((state == SHIFT) && !pause) begin
        bit_out   <= next_bit;
        shreg     <= shifted;
        bits_left <= bits_left - BL_W'(1);
      end else if (state == IDLE) begin
        bit_out   <= 1'b0;
        bit_valid <= 1'b0;
      end
    end
  end

endmodule
